ro_freq_meter_ctrl: RTL and testbench
=====================================

# ro_freq_meter_ctrl

Measurement controller for the on-die ring oscillator. It enables the ring, waits for the ring to settle, and counts rising edges of the ring's divided tap over a programmable window of `clk` cycles. The result is latched for parallel readout and can also be shifted out serially over a single pin. It sits between the pin-facing top level and the `ring_osc` instance, and it owns the ring's enable.

## Interface
Parameters:
- `CNT_W`, 16: width of the edge counter and result.
- `GATE_W`, 16: width of the measurement window length.
- `SETTLE_CYCLES`, 16: `clk` cycles spent in SETTLE (≥4).

Ports:
- `clk`  in  1  — the single clock; all logic is on its rising edge.
- `rst_n`  in  1  — reset, asynchronous and active-low; deassertion is used directly.
- `start`  in  1  — request a measurement; sampled only in IDLE.
- `abort`  in  1  — return to IDLE from any state; `count` is left unchanged.
- `mode`  in  1  — 0 = single-shot, 1 = continuous; sampled with `start`.
- `gate_cycles`  in  GATE_W  — window length in `clk` cycles; sampled with `start`; 0 is treated as 1.
- `ring_tap`  in  1  — asynchronous divided ring output (e.g. ring/16).
- `shift_en`  in  1  — shift the serial register by one bit per cycle; ignored while `busy`.
- `ring_ena`  out  1  — drives the ring oscillator's enable.
- `busy`  out  1  — high in SETTLE and MEASURE.
- `done`  out  1  — sticky; set at result latch; cleared by accepted `start`, by `abort`, or by reset.
- `result_stb`  out  1  — one-cycle pulse on each result latch.
- `count`  out  CNT_W  — last latched edge count.
- `overflow`  out  1  — latched with `count`; set if the counter saturated.
- `sout`  out  1  — MSB of the serial shift register.

## Operation
- **Synchronizer:** `ring_tap` passes through 2 flops (s1, s2) plus a history flop s3. A rising edge is `s2 & ~s3`. Synchronizer flops run in every state.
- **State machine:** IDLE, SETTLE, MEASURE.
  - **IDLE:** `ring_ena`=0, `busy`=0. On `start`=1 and `abort`=0:
    - latch `mode` and `gate_cycles` (0→1);
    - clear `done`;
    - clear the settle counter;
    - go to SETTLE.
  - **SETTLE:** `ring_ena`=1. Wait exactly SETTLE_CYCLES cycles, then go to MEASURE with edge counter = 0 and gate counter = latched `gate_cycles`. Edges seen during SETTLE are discarded.
  - **MEASURE:** `ring_ena`=1.
    - Each cycle: gate counter decrements; a detected edge increments the edge counter.
    - The counter saturates at all-ones and sets an internal overflow flag.
    - The edge-detect result in the last window cycle (gate counter =1) is counted.
    - After that last cycle:
      - latch `count` and `overflow`;
      - load the shift register with the count;
      - assert `result_stb`;
      - set `done`.
    - Next state: IDLE if mode=0 (`ring_ena` drops the same cycle `done` rises); if mode=1, MEASURE again with the counters reloaded, no gap cycle and no re-settle.
- **Abort:** `abort`=1 in any state forces IDLE next cycle.
  - `ring_ena`, `busy`, `done` → 0.
  - `count`, `overflow` and the shift register are unchanged; no `result_stb`.
  - `abort` takes priority over `start` and over a coincident latch.
- **Shift register:**
  - When `shift_en`=1 and `busy`=0, it shifts left by one and fills with 0; `sout` = MSB.
  - A latch in the same cycle as `shift_en` loads and does not shift. In continuous mode the latch occurs while `busy`=0 is false, so shifting requires abort or mode=0.
- **Reset values:** `ring_ena`, `busy`, `done`, `result_stb`, `overflow`, `sout` = 0; `count` = 0; state IDLE; all counters and synchronizer flops = 0.

## Timing
- `start` is sampled at edge T0.
  - T0+1: SETTLE, `ring_ena`=`busy`=1.
  - T0+1+SETTLE_CYCLES: first MEASURE cycle.
  - `result_stb`/`done` high at T0+1+SETTLE_CYCLES+G, where G = effective gate.
- Synchronizer latency: a tap edge is counted 2–3 cycles after it occurs. Edges closer than 2 `clk` periods apart may be missed; the tap division must guarantee a period of at least 4 `clk`.
- **Continuous mode:** `result_stb` every G cycles exactly; `count` updates on the same edge as the strobe.
- **Arithmetic:** maximum count without overflow is 2^CNT_W−1. Frequency = count·div·f_clk/G (software-side).

## Test plan
- **Tap toggling, SETTLE_CYCLES=16:** tap toggles every 5 `clk` (period 10), G=100, mode 0 → `result_stb` at T0+117; `count`=10 (±1); `overflow`=0; `ring_ena` low from T0+117.
- **Gate 0 vs gate 1:** `gate_cycles`=0 → behaves as G=1: `count`∈{0,1}, `done` at T0+18.
- **Saturation:** CNT_W=4, tap period 4, G=200 → `count`=15, `overflow`=1.
- **Continuous mode:** mode 1, G=50, tap period 10 → `result_stb` pulses every 50 cycles, `count`≈5 each time; `ring_ena` stays 1 throughout.
- **Abort mid-MEASURE:** abort asserted mid-MEASURE after a prior result of 7 → next cycle IDLE; `ring_ena`=0, `done`=0, `count` still 7; no strobe.
- **Serial readout:** after `count`=0xA5C3 (CNT_W=16), 16 cycles of `shift_en` → `sout` = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1, then 0. Async reset asserted mid-SETTLE → all outputs 0 immediately.

Source files
------------

// File: rtl/ro_freq_meter_ctrl.sv
// Ring-oscillator frequency meter controller.
// Enables the ring, waits SETTLE_CYCLES for it to stabilise, then counts rising
// edges of the synchronised ring tap over a window of gate_cycles clk cycles.
// The result is latched for parallel readout and loaded into a shift register
// for serial readout on sout.
//
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   start, abort    begin a measurement (IDLE only) / return to IDLE at once
//   mode            0 single-shot, 1 continuous (sampled with start)
//   gate_cycles     window length in clk cycles (0 behaves as 1)
//   ring_tap        asynchronous divided ring output
//   shift_en        shift the serial register one bit (ignored while busy)
//   ring_ena        ring oscillator enable
//   busy            high in SETTLE and MEASURE
//   done            sticky result-available flag
//   result_stb      one-cycle pulse per latched result
//   count/overflow  last latched edge count and its saturation flag
//   sout            MSB of the serial shift register
module ro_freq_meter_ctrl #(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned GATE_W        = 16,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic              ring_tap,
  input  logic              shift_en,
  output logic              ring_ena,
  output logic              busy,
  output logic              done,
  output logic              result_stb,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              sout
);

  localparam int unsigned        SettleW    = $clog2(SETTLE_CYCLES);
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);
  localparam logic [GATE_W-1:0]  GateOne    = GATE_W'(1);
  localparam logic [CNT_W-1:0]   CntMax     = '1;

  typedef enum logic [1:0] {StIdle, StSettle, StMeasure} state_e;

  state_e              state_q, state_d;
  logic [SettleW-1:0]  settle_q, settle_d;
  logic [GATE_W-1:0]   gate_q, gate_d;
  logic [GATE_W-1:0]   gate_lat_q, gate_lat_d;
  logic                mode_q, mode_d;
  logic [CNT_W-1:0]    edge_cnt_q, edge_cnt_d;
  logic                ovf_q, ovf_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [CNT_W-1:0]    shreg_q, shreg_d;
  logic                done_q, done_d;
  logic                stb_q, stb_d;
  logic                s1_q, s2_q, s3_q;

  logic                tap_rise;
  logic                cnt_sat;
  logic [CNT_W-1:0]    cnt_inc;
  logic                ovf_now;
  logic                latch;

  // Two-flop synchroniser plus history flop; runs in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= ring_tap;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign tap_rise = s2_q & ~s3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      settle_q   <= '0;
      gate_q     <= '0;
      gate_lat_q <= '0;
      mode_q     <= 1'b0;
      edge_cnt_q <= '0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      shreg_q    <= '0;
      done_q     <= 1'b0;
      stb_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      gate_q     <= gate_d;
      gate_lat_q <= gate_lat_d;
      mode_q     <= mode_d;
      edge_cnt_q <= edge_cnt_d;
      ovf_q      <= ovf_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      shreg_q    <= shreg_d;
      done_q     <= done_d;
      stb_q      <= stb_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    gate_d     = gate_q;
    gate_lat_d = gate_lat_q;
    mode_d     = mode_q;
    edge_cnt_d = edge_cnt_q;
    ovf_d      = ovf_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    shreg_d    = shreg_q;
    done_d     = done_q;
    stb_d      = 1'b0;
    latch      = 1'b0;

    // Saturating count including the edge detected this cycle.
    cnt_sat = (edge_cnt_q == CntMax);
    cnt_inc = (tap_rise && !cnt_sat) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;
    ovf_now = ovf_q | (tap_rise & cnt_sat);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mode_d     = mode;
          gate_lat_d = (gate_cycles == '0) ? GateOne : gate_cycles;
          done_d     = 1'b0;
          settle_d   = '0;
          state_d    = StSettle;
        end
      end
      StSettle: begin
        settle_d = settle_q + SettleW'(1);
        if (settle_q == SettleLast) begin
          state_d    = StMeasure;
          gate_d     = gate_lat_q;
          edge_cnt_d = '0;
          ovf_d      = 1'b0;
        end
      end
      StMeasure: begin
        gate_d     = gate_q - GATE_W'(1);
        edge_cnt_d = cnt_inc;
        ovf_d      = ovf_now;
        if (gate_q == GateOne) begin
          latch = 1'b1;
          if (mode_q) begin
            // Back-to-back windows: reload with no gap and no re-settle.
            gate_d     = gate_lat_q;
            edge_cnt_d = '0;
            ovf_d      = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over start and over a coincident result latch.
    if (abort) begin
      state_d = StIdle;
      done_d  = 1'b0;
    end

    if (latch && !abort) begin
      count_d    = cnt_inc;
      overflow_d = ovf_now;
      shreg_d    = cnt_inc;
      stb_d      = 1'b1;
      done_d     = 1'b1;
    end else if (shift_en && (state_q == StIdle)) begin
      shreg_d = {shreg_q[CNT_W-2:0], 1'b0};
    end
  end

  assign ring_ena   = (state_q != StIdle);
  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign result_stb = stb_q;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign sout       = shreg_q[CNT_W-1];

endmodule

// File: tb/tb_ro_freq_meter_ctrl.sv
// Directed bench for ro_freq_meter_ctrl. Expected results are queued when a
// measurement is started and checked by a monitor thread at each result_stb.
// A second instance with a 4-bit counter shares all inputs for saturation.
module tb_ro_freq_meter_ctrl;

  localparam int unsigned Settle = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, mode, ring_tap, shift_en;
  logic [15:0] gate_cycles;

  logic        ring_ena, busy, done, result_stb, overflow, sout;
  logic [15:0] count;
  logic        ring_ena4, busy4, done4, result_stb4, overflow4, sout4;
  logic [3:0]  count4;

  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic        tap_free = 1'b0;
  int          tap_half = 5;

  typedef struct {
    int   lo;
    int   hi;
    logic ovf;
    int   cyc;
    logic ena;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ro_freq_meter_ctrl #(.CNT_W(16), .GATE_W(16), .SETTLE_CYCLES(Settle)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .gate_cycles(gate_cycles), .ring_tap(ring_tap), .shift_en(shift_en),
    .ring_ena(ring_ena), .busy(busy), .done(done), .result_stb(result_stb),
    .count(count), .overflow(overflow), .sout(sout)
  );

  ro_freq_meter_ctrl #(.CNT_W(4), .GATE_W(16), .SETTLE_CYCLES(Settle)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .gate_cycles(gate_cycles), .ring_tap(ring_tap), .shift_en(shift_en),
    .ring_ena(ring_ena4), .busy(busy4), .done(done4), .result_stb(result_stb4),
    .count(count4), .overflow(overflow4), .sout(sout4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tap_gen();
    int ph = 0;
    forever begin
      @(negedge clk);
      if (tap_free) begin
        if (ph >= tap_half - 1) begin
          ph = 0;
          ring_tap = ~ring_tap;
        end else begin
          ph++;
        end
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && result_stb === 1'b1) begin
        if (sb.size() == 0) begin
          chk("stray_stb", 32'(result_stb), 0);
        end else begin
          e = sb.pop_front();
          chk("stb_cycle", cyc, e.cyc);
          chk("count_range", 32'(32'(count) >= e.lo && 32'(count) <= e.hi), 1);
          chk("overflow", 32'(overflow), 32'(e.ovf));
          chk("done_at_stb", 32'(done), 1);
          chk("ena_at_stb", 32'(ring_ena), 32'(e.ena));
        end
      end
    end
  endtask

  task automatic do_start(input logic m, input logic [15:0] g, output int t0);
    t0          = cyc;
    start       = 1'b1;
    mode        = m;
    gate_cycles = g;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk("drain", sb.size(), 0);
    sb.delete();
  endtask

  // Exact pulses of period 4 clk (2 high, 2 low).
  task automatic burst(input int n);
    for (int i = 0; i < n; i++) begin
      ring_tap = 1'b1;
      repeat (2) @(negedge clk);
      ring_tap = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    int          t0;
    logic [15:0] ser_exp;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0;
    ring_tap = 1'b0; shift_en = 1'b0; gate_cycles = '0;
    fork
      tap_gen();
      monitor();
    join_none

    repeat (3) @(negedge clk);
    chk("rst_ring_ena", 32'(ring_ena), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_stb", 32'(result_stb), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_sout", 32'(sout), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single shot, tap period 10, G=100: about 10 edges, strobe at T0+117.
    tap_half = 5; tap_free = 1'b1;
    repeat (20) @(negedge clk);
    do_start(1'b0, 16'd100, t0);
    sb.push_back('{lo: 9, hi: 11, ovf: 1'b0, cyc: t0 + 1 + Settle + 100, ena: 1'b0});
    chk("a_ring_ena_t1", 32'(ring_ena), 1);
    chk("a_busy_t1", 32'(busy), 1);
    wait_drain(200);
    repeat (3) @(negedge clk);
    chk("a_done_sticky", 32'(done), 1);
    chk("a_stb_pulse", 32'(result_stb), 0);

    // Gate 0 behaves as a one-cycle window.
    do_start(1'b0, 16'd0, t0);
    sb.push_back('{lo: 0, hi: 1, ovf: 1'b0, cyc: t0 + 1 + Settle + 1, ena: 1'b0});
    chk("g0_done_cleared", 32'(done), 0);
    wait_drain(60);

    // Tap period 4, G=200: 16-bit counter sees ~50, 4-bit counter saturates.
    tap_half = 2;
    repeat (10) @(negedge clk);
    do_start(1'b0, 16'd200, t0);
    sb.push_back('{lo: 49, hi: 51, ovf: 1'b0, cyc: t0 + 1 + Settle + 200, ena: 1'b0});
    wait_drain(300);
    chk("sat_count4", 32'(count4), 15);
    chk("sat_overflow4", 32'(overflow4), 1);

    // Continuous, G=50, tap period 10: strobe every 50 cycles, ring stays on.
    tap_half = 5;
    repeat (10) @(negedge clk);
    do_start(1'b1, 16'd50, t0);
    for (int k = 1; k <= 4; k++)
      sb.push_back('{lo: 4, hi: 6, ovf: 1'b0, cyc: t0 + 1 + Settle + 50 * k, ena: 1'b1});
    wait_drain(300);
    repeat (20) @(negedge clk);
    chk("cont_ena_on", 32'(ring_ena), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("cont_abort_ena", 32'(ring_ena), 0);
    chk("cont_abort_busy", 32'(busy), 0);
    chk("cont_abort_done", 32'(done), 0);
    repeat (80) @(negedge clk);

    // Exact 7 pulses inside the window, then abort a later run mid-MEASURE.
    tap_free = 1'b0; ring_tap = 1'b0;
    repeat (5) @(negedge clk);
    do_start(1'b0, 16'd100, t0);
    sb.push_back('{lo: 7, hi: 7, ovf: 1'b0, cyc: t0 + 1 + Settle + 100, ena: 1'b0});
    repeat (30) @(negedge clk);
    burst(7);
    wait_drain(150);
    tap_free = 1'b1;
    do_start(1'b0, 16'd100, t0);
    repeat (50) @(negedge clk);
    chk("ab_busy_before", 32'(busy), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_ring_ena", 32'(ring_ena), 0);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_done", 32'(done), 0);
    chk("ab_count_kept", 32'(count), 7);
    chk("ab_stb", 32'(result_stb), 0);
    repeat (100) @(negedge clk);

    // Exact 707 pulses -> 0x02C3, then read it out serially MSB first.
    tap_free = 1'b0; ring_tap = 1'b0;
    repeat (5) @(negedge clk);
    do_start(1'b0, 16'd2900, t0);
    sb.push_back('{lo: 707, hi: 707, ovf: 1'b0, cyc: t0 + 1 + Settle + 2900, ena: 1'b0});
    repeat (30) @(negedge clk);
    burst(707);
    wait_drain(200);
    ser_exp = 16'h02C3;
    chk("ser_count", 32'(count), 32'(ser_exp));
    for (int i = 15; i >= 0; i--) begin
      chk($sformatf("sout_bit%0d", i), 32'(sout), 32'(ser_exp[i]));
      shift_en = 1'b1;
      @(negedge clk);
    end
    shift_en = 1'b0;
    chk("sout_drained", 32'(sout), 0);
    chk("count_after_shift", 32'(count), 32'(ser_exp));

    // Asynchronous reset in the middle of SETTLE clears outputs immediately.
    tap_free = 1'b1;
    do_start(1'b0, 16'd100, t0);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ring_ena", 32'(ring_ena), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_stb", 32'(result_stb), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_overflow", 32'(overflow), 0);
    chk("arst_sout", 32'(sout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
